// File: rtl/if_stage_pkg.sv
// ----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage: default widths, the
// reset PC, the instruction size in bytes and the fetch FSM state type.
// No ports (package).
// ----------------------------------------------------------------------------
package if_stage_pkg;

   localparam int          ADDR_W_DEF   = 64;
   localparam int          INSTR_W_DEF  = 32;
   localparam logic [63:0] RESET_PC_DEF = 64'h0;
   localparam int          INSTR_BYTES  = 4;

   // S_REQ  : request outstanding to instruction memory
   // S_HOLD : a fetched instruction is parked while the pipe is stalled
   typedef enum logic {
      S_REQ  = 1'b0,
      S_HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if
// Instruction-memory request/ready bus between the fetch stage and imem.
//   imem_req   : fetch request valid                    (master -> slave)
//   imem_addr  : fetch address                          (master -> slave)
//   imem_ready : request accepted, rdata valid same cycle (slave -> master)
//   imem_rdata : fetched instruction                    (slave -> master)
// ----------------------------------------------------------------------------
interface if_stage_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
);

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ready;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

// File: rtl/if_stage_mux.sv
// ----------------------------------------------------------------------------
// if_stage_mux
// 2:1 next-PC mux.
//   in_1   : selected when signal = 0 (sequential PC)
//   in_2   : selected when signal = 1 (branch target)
//   signal : select
//   out    : selected value
// ----------------------------------------------------------------------------
module if_stage_mux #(
   parameter int W = 64
) (
   input  logic [W-1:0] in_1,
   input  logic [W-1:0] in_2,
   input  logic         signal,
   output logic [W-1:0] out
);

   assign out = signal ? in_2 : in_1;

endmodule

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: holds the PC, fetches from instruction memory over
// a req/ready handshake and loads the IF/ID pipeline register. Handles stall,
// flush and branch redirect from downstream hazard/branch logic.
//   clk, reset      : clock, synchronous active-high reset
//   pc_src          : redirect to branch_target
//   branch_target   : redirect address (low two bits ignored)
//   stall           : hold PC and IF/ID
//   flush           : invalidate IF/ID, refetch current PC
//   imem            : instruction-memory bus (master side)
//   ifid_pc/instr   : IF/ID pipeline register contents
//   ifid_valid      : IF/ID holds a real instruction
// ----------------------------------------------------------------------------
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                INSTR_W  = INSTR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pc_src,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               stall,
   input  logic               flush,
   if_stage_if.master         imem,
   output logic [ADDR_W-1:0]  ifid_pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic               ifid_valid
);

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  pc, pc_nxt, pc_seq, target_aligned, pc_mux;
   logic [INSTR_W-1:0] hold_instr, hold_instr_nxt;
   logic [ADDR_W-1:0]  ifid_pc_nxt;
   logic [INSTR_W-1:0] ifid_instr_nxt;
   logic               ifid_valid_nxt;
   logic               hs;

   // Request is suppressed during reset so memory never sees a stray fetch.
   assign imem.imem_addr = pc;
   assign imem.imem_req  = (state == S_REQ) && !reset;
   assign hs             = imem.imem_req && imem.imem_ready;

   // Sequential PC wraps naturally modulo 2^ADDR_W.
   assign pc_seq         = pc + ADDR_W'(INSTR_BYTES);
   assign target_aligned = {branch_target[ADDR_W-1:2], 2'b00};

   if_stage_mux #(
      .W (ADDR_W)
   ) u_next_pc (
      .in_1   (pc_seq),
      .in_2   (target_aligned),
      .signal (pc_src),
      .out    (pc_mux)
   );

   // Next-state / datapath selection. Priority: pc_src > flush > stall.
   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      hold_instr_nxt = hold_instr;
      ifid_pc_nxt    = ifid_pc;
      ifid_instr_nxt = ifid_instr;
      ifid_valid_nxt = ifid_valid;

      if (pc_src) begin
         pc_nxt         = pc_mux;
         ifid_valid_nxt = 1'b0;
         state_nxt      = S_REQ;
      end else if (flush) begin
         // PC is kept so the dropped instruction is fetched again.
         ifid_valid_nxt = 1'b0;
         state_nxt      = S_REQ;
      end else begin
         case (state)
            S_REQ: begin
               if (hs) begin
                  if (stall) begin
                     hold_instr_nxt = imem.imem_rdata;
                     state_nxt      = S_HOLD;
                  end else begin
                     ifid_pc_nxt    = pc;
                     ifid_instr_nxt = imem.imem_rdata;
                     ifid_valid_nxt = 1'b1;
                     pc_nxt         = pc_mux;
                  end
               end else if (!stall) begin
                  ifid_valid_nxt = 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  ifid_pc_nxt    = pc;
                  ifid_instr_nxt = hold_instr;
                  ifid_valid_nxt = 1'b1;
                  pc_nxt         = pc_mux;
                  state_nxt      = S_REQ;
               end
            end
            default: state_nxt = S_REQ;
         endcase
      end
   end

   // IF -> ID register boundary
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_REQ;
         pc         <= RESET_PC;
         hold_instr <= '0;
         ifid_pc    <= '0;
         ifid_instr <= '0;
         ifid_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         hold_instr <= hold_instr_nxt;
         ifid_pc    <= ifid_pc_nxt;
         ifid_instr <= ifid_instr_nxt;
         ifid_valid <= ifid_valid_nxt;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// against a behavioural fetch model. A second instance with a high reset PC
// exercises PC wrap-around.
// ----------------------------------------------------------------------------
module tb_if_stage;
   import if_stage_pkg::*;

   localparam int          AW   = 64;
   localparam int          IW   = 32;
   localparam logic [63:0] RPC2 = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [31:0] SALT = 32'hC0DE_0000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          pc_src = 1'b0;
   logic          stall = 1'b0;
   logic          flush = 1'b0;
   logic [63:0]   branch_target = '0;
   logic [63:0]   ifid_pc, ifid_pc2;
   logic [31:0]   ifid_instr, ifid_instr2;
   logic          ifid_valid, ifid_valid2;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model of the fetch stage
   logic [63:0] m_pc;
   logic        m_hold;
   logic [31:0] m_hold_instr;
   logic [63:0] m_ifid_pc;
   logic [31:0] m_ifid_instr;
   logic        m_ifid_valid;

   if_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) bus  ();
   if_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) bus2 ();

   if_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(64'h0)) dut (
      .clk           (clk),
      .reset         (reset),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .stall         (stall),
      .flush         (flush),
      .imem          (bus),
      .ifid_pc       (ifid_pc),
      .ifid_instr    (ifid_instr),
      .ifid_valid    (ifid_valid)
   );

   if_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC2)) dut2 (
      .clk           (clk),
      .reset         (reset),
      .pc_src        (1'b0),
      .branch_target (64'h0),
      .stall         (1'b0),
      .flush         (1'b0),
      .imem          (bus2),
      .ifid_pc       (ifid_pc2),
      .ifid_instr    (ifid_instr2),
      .ifid_valid    (ifid_valid2)
   );

   // Memory for the wrap instance: always ready, data derived from address.
   assign bus2.imem_ready = 1'b1;
   assign bus2.imem_rdata = bus2.imem_addr[31:0] ^ SALT;

   always #5 clk = ~clk;

   // Advance one clock; the model applies the fetch rules to the inputs
   // present before the edge. Outputs are then sampled 1 time unit later.
   task automatic tick();
      logic req, hs;
      req = !reset && !m_hold;
      hs  = req && bus.imem_ready;
      if (reset) begin
         m_pc = 64'h0; m_hold = 1'b0; m_hold_instr = '0;
         m_ifid_pc = '0; m_ifid_instr = '0; m_ifid_valid = 1'b0;
      end else if (pc_src) begin
         m_pc = {branch_target[63:2], 2'b00};
         m_hold = 1'b0; m_ifid_valid = 1'b0;
      end else if (flush) begin
         m_hold = 1'b0; m_ifid_valid = 1'b0;
      end else if (m_hold) begin
         if (!stall) begin
            m_ifid_pc = m_pc; m_ifid_instr = m_hold_instr; m_ifid_valid = 1'b1;
            m_pc = m_pc + 64'd4; m_hold = 1'b0;
         end
      end else if (hs) begin
         if (stall) begin
            m_hold = 1'b1; m_hold_instr = bus.imem_rdata;
         end else begin
            m_ifid_pc = m_pc; m_ifid_instr = bus.imem_rdata; m_ifid_valid = 1'b1;
            m_pc = m_pc + 64'd4;
         end
      end else if (!stall) begin
         m_ifid_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; pc_src = 1'b0; stall = 1'b0; flush = 1'b0;
      bus.imem_ready = 1'b0; bus.imem_rdata = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.imem_rdata = $urandom;
         tick();
         vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %0h want 0", bus.imem_req); end
         vectors++; if (bus.imem_addr !== 64'h0) begin miscompares++; $display("FAIL reset_addr got %0h want 0", bus.imem_addr); end
         vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0h want 0", ifid_valid); end
         vectors++; if (ifid_pc !== 64'h0) begin miscompares++; $display("FAIL reset_ifid_pc got %0h want 0", ifid_pc); end
         vectors++; if (ifid_instr !== 32'h0) begin miscompares++; $display("FAIL reset_ifid_instr got %0h want 0", ifid_instr); end
         vectors++; if (bus2.imem_addr !== RPC2) begin miscompares++; $display("FAIL reset_pc_param got %0h want %0h", bus2.imem_addr, RPC2); end
      end
   endtask

   task automatic test_stream();
      do_reset();
      bus.imem_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         bus.imem_rdata = 32'hA0 + n;
         tick();
         vectors++; if (ifid_pc !== 64'(4 * n)) begin miscompares++; $display("FAIL stream_pc got %0h want %0h", ifid_pc, 4 * n); end
         vectors++; if (ifid_instr !== 32'(32'hA0 + n)) begin miscompares++; $display("FAIL stream_instr got %0h want %0h", ifid_instr, 32'hA0 + n); end
         vectors++; if (ifid_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid got %0h want 1", ifid_valid); end
      end
   endtask

   task automatic test_ready_low();
      do_reset();
      bus.imem_ready = 1'b1;
      repeat (2) begin bus.imem_rdata = $urandom; tick(); end
      bus.imem_ready = 1'b0;
      repeat (3) begin
         bus.imem_rdata = $urandom;
         tick();
         vectors++; if (bus.imem_addr !== 64'd8) begin miscompares++; $display("FAIL rdylow_addr got %0h want 8", bus.imem_addr); end
         vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL rdylow_valid got %0h want 0", ifid_valid); end
         vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL rdylow_req got %0h want 1", bus.imem_req); end
      end
      bus.imem_ready = 1'b1; bus.imem_rdata = 32'h1234_5678;
      tick();
      vectors++; if (ifid_pc !== 64'd8) begin miscompares++; $display("FAIL rdylow_deliver_pc got %0h want 8", ifid_pc); end
      vectors++; if (ifid_instr !== 32'h1234_5678) begin miscompares++; $display("FAIL rdylow_deliver_instr got %0h want 12345678", ifid_instr); end
      vectors++; if (ifid_valid !== 1'b1) begin miscompares++; $display("FAIL rdylow_deliver_valid got %0h want 1", ifid_valid); end
   endtask

   // Continues from test_ready_low (pc = 12).
   task automatic test_stall();
      bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_0C0C;
      tick();
      stall = 1'b1; bus.imem_rdata = 32'hDEAD_0010;
      for (int i = 0; i < 2; i++) begin
         tick();
         bus.imem_rdata = $urandom;
         vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req got %0h want 0", bus.imem_req); end
         vectors++; if (ifid_pc !== 64'd12) begin miscompares++; $display("FAIL stall_frozen_pc got %0h want c", ifid_pc); end
         vectors++; if (ifid_instr !== 32'h0000_0C0C) begin miscompares++; $display("FAIL stall_frozen_instr got %0h want c0c", ifid_instr); end
         vectors++; if (bus.imem_addr !== 64'd16) begin miscompares++; $display("FAIL stall_addr got %0h want 10", bus.imem_addr); end
      end
      stall = 1'b0; bus.imem_ready = 1'b0;
      tick();
      vectors++; if (ifid_pc !== 64'd16) begin miscompares++; $display("FAIL unstall_pc got %0h want 10", ifid_pc); end
      vectors++; if (ifid_instr !== 32'hDEAD_0010) begin miscompares++; $display("FAIL unstall_instr got %0h want dead0010", ifid_instr); end
      vectors++; if (ifid_valid !== 1'b1) begin miscompares++; $display("FAIL unstall_valid got %0h want 1", ifid_valid); end
      vectors++; if (bus.imem_addr !== 64'd20) begin miscompares++; $display("FAIL unstall_addr got %0h want 14", bus.imem_addr); end
   endtask

   // Continues from test_stall (pc = 20, S_REQ).
   task automatic test_branch();
      stall = 1'b1; bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0000_BEEF;
      tick();
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL branch_hold_req got %0h want 0", bus.imem_req); end
      pc_src = 1'b1; branch_target = 64'h1003;
      tick();
      vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL branch_valid got %0h want 0", ifid_valid); end
      vectors++; if (bus.imem_addr !== 64'h1000) begin miscompares++; $display("FAIL branch_addr got %0h want 1000", bus.imem_addr); end
      vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL branch_req got %0h want 1", bus.imem_req); end
      pc_src = 1'b0; stall = 1'b0; bus.imem_rdata = 32'h1000_AAAA;
      tick();
      vectors++; if (ifid_pc !== 64'h1000) begin miscompares++; $display("FAIL branch_deliver_pc got %0h want 1000", ifid_pc); end
      vectors++; if (ifid_instr !== 32'h1000_AAAA) begin miscompares++; $display("FAIL branch_deliver_instr got %0h want 1000aaaa", ifid_instr); end
      vectors++; if (bus.imem_addr !== 64'h1004) begin miscompares++; $display("FAIL branch_next_addr got %0h want 1004", bus.imem_addr); end
   endtask

   task automatic test_flush();
      do_reset();
      bus.imem_ready = 1'b1;
      repeat (6) begin bus.imem_rdata = $urandom; tick(); end
      flush = 1'b1; bus.imem_rdata = 32'hFFFF_0018;
      tick();
      vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %0h want 0", ifid_valid); end
      vectors++; if (bus.imem_addr !== 64'd24) begin miscompares++; $display("FAIL flush_addr got %0h want 18", bus.imem_addr); end
      flush = 1'b0; bus.imem_rdata = 32'h0000_0018;
      tick();
      vectors++; if (ifid_pc !== 64'd24) begin miscompares++; $display("FAIL refetch_pc got %0h want 18", ifid_pc); end
      vectors++; if (ifid_instr !== 32'h0000_0018) begin miscompares++; $display("FAIL refetch_instr got %0h want 18", ifid_instr); end
      vectors++; if (ifid_valid !== 1'b1) begin miscompares++; $display("FAIL refetch_valid got %0h want 1", ifid_valid); end
      // flush + stall + handshake together: flush wins, no hold is entered
      flush = 1'b1; stall = 1'b1; bus.imem_rdata = 32'h0000_001C;
      tick();
      vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL flushstall_valid got %0h want 0", ifid_valid); end
      vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL flushstall_req got %0h want 1", bus.imem_req); end
      vectors++; if (bus.imem_addr !== 64'd28) begin miscompares++; $display("FAIL flushstall_addr got %0h want 1c", bus.imem_addr); end
      flush = 1'b0; stall = 1'b0;
      tick();
      vectors++; if (ifid_pc !== 64'd28) begin miscompares++; $display("FAIL flushstall_refetch_pc got %0h want 1c", ifid_pc); end
   endtask

   task automatic test_wrap();
      logic [63:0] exp_pc;
      do_reset();
      bus.imem_ready = 1'b1;
      exp_pc = RPC2;
      for (int i = 0; i < 3; i++) begin
         bus.imem_rdata = $urandom;
         tick();
         vectors++; if (ifid_pc2 !== exp_pc) begin miscompares++; $display("FAIL wrap_pc got %0h want %0h", ifid_pc2, exp_pc); end
         vectors++; if (ifid_instr2 !== (exp_pc[31:0] ^ SALT)) begin miscompares++; $display("FAIL wrap_instr got %0h want %0h", ifid_instr2, exp_pc[31:0] ^ SALT); end
         vectors++; if (ifid_valid2 !== 1'b1) begin miscompares++; $display("FAIL wrap_valid got %0h want 1", ifid_valid2); end
         exp_pc = exp_pc + 64'd4;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         reset          = ($urandom_range(0, 59) == 0);
         pc_src         = ($urandom_range(0, 9) == 0);
         flush          = ($urandom_range(0, 9) == 0);
         stall          = ($urandom_range(0, 3) == 0);
         bus.imem_ready = ($urandom_range(0, 2) != 0);
         bus.imem_rdata = $urandom;
         branch_target  = {$urandom, $urandom};
         tick();
         vectors++; if (bus.imem_req !== (!reset && !m_hold)) begin miscompares++; $display("FAIL rand_req cyc %0d got %0h want %0h", i, bus.imem_req, !reset && !m_hold); end
         vectors++; if (bus.imem_addr !== m_pc) begin miscompares++; $display("FAIL rand_addr cyc %0d got %0h want %0h", i, bus.imem_addr, m_pc); end
         vectors++; if (ifid_valid !== m_ifid_valid) begin miscompares++; $display("FAIL rand_valid cyc %0d got %0h want %0h", i, ifid_valid, m_ifid_valid); end
         if (m_ifid_valid) begin
            vectors++; if (ifid_pc !== m_ifid_pc) begin miscompares++; $display("FAIL rand_pc cyc %0d got %0h want %0h", i, ifid_pc, m_ifid_pc); end
            vectors++; if (ifid_instr !== m_ifid_instr) begin miscompares++; $display("FAIL rand_instr cyc %0d got %0h want %0h", i, ifid_instr, m_ifid_instr); end
         end
      end
      reset = 1'b0; pc_src = 1'b0; flush = 1'b0; stall = 1'b0;
   endtask

   initial begin
      bus.imem_ready = 1'b0;
      bus.imem_rdata = '0;
      test_reset();
      test_stream();
      test_ready_low();
      test_stall();
      test_branch();
      test_flush();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
